vga_scan_ctrl: RTL and testbench

- Generates the pixel scan for the VGA path: counts the 640x480@60 timing and drives pixelX/pixelY to all drawing blocks.
- Takes back the merged 8-bit RGB (RRRGGGBB) those blocks return, expands it to 4:4:4 and drives the VGA DAC pins with matching hsync/vsync.
- The sync and blank signals are delayed by a fixed pipeline depth so they line up with the registered drawer outputs.
- Also issues the per-frame startOfFrame pulse that game logic uses to update positions.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_sync_delay.sv | 41 ++++
 rtl/vga_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_scan_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and colour types for the VGA scan path.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int unsigned CNT_W          = 11;
    localparam int unsigned MAX_PIPE_DELAY = 4;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Replicate the top bits so full-scale 3/2-bit values map to full-scale 4-bit.
    function automatic rgb444_t expand_rgb332(input rgb332_t c);
        rgb444_t o;
        o.r = {c[7:5], c[7]};
        o.g = {c[4:2], c[4]};
        o.b = {c[1:0], c[1:0]};
        return o;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage, W-bit shift register whose stages all load rst_val on reset.
module vga_sync_delay #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (N == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, reset, rst_val};
            assign dout = din;
        end else begin : g_shift
            logic [N*W-1:0]     stage_q;
            logic [N*W-1:0]     stage_d;
            logic [(N+1)*W-1:0] chain;

            // Oldest stage sits at the top of the chain; din enters at the bottom.
            assign chain = {stage_q, din};
            assign dout  = chain[(N+1)*W-1 -: W];

            always_comb begin
                stage_d = chain[N*W-1:0];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_q <= {N{rst_val}};
                end else begin
                    stage_q <= stage_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan generator: pixel counters, sync/blank decode delayed to match the
// drawer pipeline, RGB332 -> RGB444 output register and a start-of-frame pulse.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned PIPE_DELAY  = 2,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned H_ACT   = H_VISIBLE,
    parameter int unsigned H_FRONT = H_FP,
    parameter int unsigned H_PULSE = H_SYNC,
    parameter int unsigned H_BACK  = H_BP,
    parameter int unsigned V_ACT   = V_VISIBLE,
    parameter int unsigned V_FRONT = V_FP,
    parameter int unsigned V_PULSE = V_SYNC,
    parameter int unsigned V_BACK  = V_BP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        RGB_in,
    output logic [CNT_W-1:0]  pixelX,
    output logic [CNT_W-1:0]  pixelY,
    output logic              startOfFrame,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hsync,
    output logic              vsync,
    output logic              blankN
);

    localparam int unsigned H_TOT = H_ACT + H_FRONT + H_PULSE + H_BACK;
    localparam int unsigned V_TOT = V_ACT + V_FRONT + V_PULSE + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] H_SYNC_LO = CNT_W'(H_ACT + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_HI = CNT_W'(H_ACT + H_FRONT + H_PULSE);
    localparam logic [CNT_W-1:0] V_SYNC_LO = CNT_W'(V_ACT + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_HI = CNT_W'(V_ACT + V_FRONT + V_PULSE);

    generate
        if (PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_pipe_delay
            $error("vga_scan_ctrl: PIPE_DELAY must be within 0..4");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_wrap;
    logic             sof_q, sof_d;

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        // Registered so the pulse coincides with the counters reading (0, V_ACT).
        sof_d = (h_cnt_d == '0) && (v_cnt_d == V_ACT_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            sof_q   <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            sof_q   <= sof_d;
        end
    end

    logic       active_raw, hs_raw, vs_raw;
    logic [2:0] raw_bits, idle_bits, dly_bits;

    always_comb begin
        active_raw = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hs_raw     = ((h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_raw     = ((v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        raw_bits   = {active_raw, hs_raw, vs_raw};
        idle_bits  = {1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE};
    end

    vga_sync_delay #(
        .N (PIPE_DELAY),
        .W (3)
    ) u_sync_delay (
        .clk     (clk),
        .reset   (reset),
        .rst_val (idle_bits),
        .din     (raw_bits),
        .dout    (dly_bits)
    );

    rgb444_t rgb_q, rgb_d;
    logic    blank_n_q, blank_n_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;

    // Output register: RGB_in arrives here in step with the delayed sync bits.
    always_comb begin
        blank_n_d = dly_bits[2];
        hsync_d   = dly_bits[1];
        vsync_d   = dly_bits[0];
        rgb_d     = dly_bits[2] ? expand_rgb332(RGB_in) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q     <= '0;
            blank_n_q <= 1'b0;
            hsync_q   <= ~SYNC_ACTIVE;
            vsync_q   <= ~SYNC_ACTIVE;
        end else begin
            rgb_q     <= rgb_d;
            blank_n_q <= blank_n_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign pixelX       = h_cnt_q;
    assign pixelY       = v_cnt_q;
    assign startOfFrame = sof_q;
    assign red          = rgb_q.r;
    assign green        = rgb_q.g;
    assign blue         = rgb_q.b;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blankN       = blank_n_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl: full-timing PIPE_DELAY=2 instance plus a shrunken
// 16x9 timing PIPE_DELAY=0 instance for frame-level and zero-delay behaviour.
module tb_vga_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rgb_in = 8'h00;

    logic [10:0] px, py;
    logic        sof, hs, vs, bl;
    logic [3:0]  red, green, blue;

    logic [10:0] s_px, s_py;
    logic        s_sof, s_hs, s_vs, s_bl;
    logic [3:0]  s_red, s_green, s_blue;

    int checks = 0;
    int passed = 0;
    int e_cnt  = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        int         e;
        logic [7:0] rgb;
        int         px;
        int         py;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    vga_scan_ctrl #(
        .PIPE_DELAY  (2),
        .SYNC_ACTIVE (1'b0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RGB_in       (rgb_in),
        .pixelX       (px),
        .pixelY       (py),
        .startOfFrame (sof),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync        (hs),
        .vsync        (vs),
        .blankN       (bl)
    );

    vga_scan_ctrl #(
        .PIPE_DELAY  (0),
        .SYNC_ACTIVE (1'b0),
        .H_ACT       (8),
        .H_FRONT     (2),
        .H_PULSE     (3),
        .H_BACK      (3),
        .V_ACT       (4),
        .V_FRONT     (1),
        .V_PULSE     (2),
        .V_BACK      (2)
    ) dut_s (
        .clk          (clk),
        .reset        (reset),
        .RGB_in       (rgb_in),
        .pixelX       (s_px),
        .pixelY       (s_py),
        .startOfFrame (s_sof),
        .red          (s_red),
        .green        (s_green),
        .blue         (s_blue),
        .hsync        (s_hs),
        .vsync        (s_vs),
        .blankN       (s_bl)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s @e=%0d: got %0d expected %0d", name, e_cnt, act, exp);
        end
    endtask

    // One clock; e_cnt counts edges since the last reset edge. Returns on the negedge.
    task automatic tick();
        @(posedge clk);
        if (reset) e_cnt = 0;
        else       e_cnt++;
        @(negedge clk);
    endtask

    int hs_low, hs_fall, s_hs_fall, vlow0, vlow1, sof_seen;

    initial begin
        //          e    rgb            px   py hs    vs    bl    r     g     b
        vecs[0]  = '{0,   8'hFF,         0,   0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{1,   8'hFF,         1,   0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{2,   8'hFF,         2,   0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{3,   8'hFF,         3,   0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF};
        vecs[4]  = '{10,  8'b100_010_01, 10,  0, 1'b1, 1'b1, 1'b1, 4'h9, 4'h4, 4'h5};
        vecs[5]  = '{642, 8'hFF,         642, 0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'hF};
        vecs[6]  = '{643, 8'hFF,         643, 0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[7]  = '{658, 8'hFF,         658, 0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[8]  = '{659, 8'hFF,         659, 0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[9]  = '{754, 8'hFF,         754, 0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{755, 8'hFF,         755, 0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[11] = '{799, 8'hFF,         799, 0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{800, 8'hFF,         0,   1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0};
        vecs[13] = '{803, 8'h00,         3,   1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0};
        vecs[14] = '{804, 8'h76,         4,   1, 1'b1, 1'b1, 1'b1, 4'h6, 4'hB, 4'hA};

        // Reset held for 5 clocks, then the table walks the first line and a half.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            rgb_in = vecs[i].rgb;
            while (e_cnt < vecs[i].e) tick();
            check("px",    px,    vecs[i].px);
            check("py",    py,    vecs[i].py);
            check("hsync", hs,    vecs[i].hs);
            check("vsync", vs,    vecs[i].vs);
            check("blank", bl,    vecs[i].bl);
            check("red",   red,   vecs[i].r);
            check("green", green, vecs[i].g);
            check("blue",  blue,  vecs[i].b);
            check("sof",   sof,   0);
        end

        // Mid-frame reset while a sync pulse is in flight through the pipe.
        rgb_in = 8'hFF;
        while (e_cnt < 2300) tick();
        check("pre_rst_px", px, 700);
        check("pre_rst_py", py, 2);
        check("pre_rst_hs", hs, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        rgb_in = 8'b100_010_01;

        check("rst_px",    px,    0);
        check("rst_py",    py,    0);
        check("rst_hs",    hs,    1);
        check("rst_vs",    vs,    1);
        check("rst_bl",    bl,    0);
        check("rst_red",   red,   0);
        check("rst_sof",   sof,   0);
        check("s_rst_bl",  s_bl,  0);
        check("s_rst_red", s_red, 0);
        check("s_rst_hs",  s_hs,  1);

        hs_low    = 0;
        hs_fall   = -1;
        s_hs_fall = -1;
        vlow0     = 0;
        vlow1     = 0;
        sof_seen  = 0;
        exp_q.push_back(16'd64);
        exp_q.push_back(16'd208);

        for (int k = 1; k <= 800; k++) begin
            tick();
            if (hs == 1'b0) begin
                hs_low++;
                if (hs_fall < 0) hs_fall = e_cnt;
            end
            if (e_cnt <= 2) begin
                check("refill_px", px, e_cnt);
                check("refill_hs", hs, 1);
                check("refill_vs", vs, 1);
                check("refill_bl", bl, 0);
                check("refill_red", red, 0);
            end
            if (e_cnt == 3) begin
                check("first_bl",    bl,    1);
                check("first_red",   red,   9);
                check("first_green", green, 4);
                check("first_blue",  blue,  5);
            end
            if (e_cnt == 1) begin
                check("s_pd0_bl",    s_bl,    1);
                check("s_pd0_red",   s_red,   9);
                check("s_pd0_green", s_green, 4);
                check("s_pd0_blue",  s_blue,  5);
            end
            if (e_cnt == 9) begin
                check("s_pd0_blank_bl",  s_bl,  0);
                check("s_pd0_blank_red", s_red, 0);
            end
            if (s_hs == 1'b0 && s_hs_fall < 0) s_hs_fall = e_cnt;
            if (e_cnt <= 288) begin
                if (s_vs == 1'b0) begin
                    if (e_cnt <= 144) vlow0++;
                    else              vlow1++;
                end
                if (s_sof) begin
                    sof_seen++;
                    check("s_sof_px", s_px, 0);
                    check("s_sof_py", s_py, 4);
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL s_sof_extra @e=%0d: got a pulse expected none", e_cnt);
                    end else begin
                        check("s_sof_cycle", e_cnt, int'(exp_q.pop_front()));
                    end
                end
            end
        end

        check("hs_low_len",   hs_low,    96);
        check("hs_first_fall", hs_fall,  659);
        check("s_hs_fall",    s_hs_fall, 11);
        check("s_vs_low_f0",  vlow0,     32);
        check("s_vs_low_f1",  vlow1,     32);
        check("s_sof_count",  sof_seen,  2);
        check("s_sof_missed", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
